// File: rtl/ds1302_pkg.sv
// Shared DS1302 definitions: BCD field offsets, time-set frame layout and parser states.
// UART_FRAME_CHECKSUM_EN adds the trailing checksum byte and the CHECK parser state.
package ds1302_pkg;

    localparam int SEC_MSB   = 55;
    localparam int SEC_LSB   = 48;
    localparam int MIN_MSB   = 47;
    localparam int MIN_LSB   = 40;
    localparam int HOUR_MSB  = 39;
    localparam int HOUR_LSB  = 32;
    localparam int DATE_MSB  = 31;
    localparam int DATE_LSB  = 24;
    localparam int MONTH_MSB = 23;
    localparam int MONTH_LSB = 16;
    localparam int DAY_MSB   = 15;
    localparam int DAY_LSB   = 8;
    localparam int YEAR_MSB  = 7;
    localparam int YEAR_LSB  = 0;

    localparam logic [7:0] HEADER_DEFAULT = 8'h55;
    localparam int         PAYLOAD_LEN    = 7;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam int         FRAME_LEN      = PAYLOAD_LEN + 2;
`else
    localparam int         FRAME_LEN      = PAYLOAD_LEN + 1;
`endif

    typedef enum logic [1:0] {
        WAIT_HDR,
`ifdef UART_FRAME_CHECKSUM_EN
        CHECK,
`endif
        PAYLOAD
    } parser_state_t;

    function automatic logic is_bcd(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchroniser, falling-edge start detection, mid-bit sampling.
module uart_rx_byte #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_vld,
    output logic       stop_err
);
    localparam int            CW      = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     state, state_nxt;
    logic [1:0]    sync;
    logic          rx_s, rx_prev;
    logic [CW-1:0] cnt;
    logic          cnt_clr;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    assign rx_s      = sync[1];
    assign byte_data = shift;

    // Synchroniser and edge detector preset high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync    <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync    <= {sync[0], rx};
            rx_prev <= sync[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RX_IDLE;
        else     state <= state_nxt;
    end

    // A low stop bit leaves the line low; re-arming needs a fresh falling edge.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        byte_vld  = 1'b0;
        stop_err  = 1'b0;
        case (state)
            RX_IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_nxt = RX_START;
                    cnt_clr   = 1'b1;
                end
            end
            RX_START: begin
                if (cnt == HALF_M1) begin
                    cnt_clr   = 1'b1;
                    state_nxt = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_clr = 1'b1;
                    if (bit_idx == 3'd7) state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == FULL_M1) begin
                    state_nxt = RX_IDLE;
                    byte_vld  = rx_s;
                    stop_err  = !rx_s;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            if (cnt_clr)             cnt <= '0;
            else if (cnt != FULL_M1) cnt <= cnt + CW'(1);
            if (state == RX_START) begin
                bit_idx <= '0;
            end else if (state == RX_DATA && cnt == FULL_M1) begin
                bit_idx <= bit_idx + 3'd1;
                shift   <= {rx_s, shift[7:1]};
            end
        end
    end

endmodule

// File: rtl/uart_time_rx.sv
// Time-set frame receiver: parses HEADER + 7 BCD bytes into a 56-bit word with a valid/ack handshake.
// UART_FRAME_CHECKSUM_EN appends a mod-256 checksum byte that must match before commit.
module uart_time_rx #(
    parameter int         CLK_FREQ    = 50_000_000,
    parameter int         BAUD        = 115200,
    parameter logic [7:0] HEADER      = ds1302_pkg::HEADER_DEFAULT,
    parameter int         TIMEOUT_CYC = 5_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        uart_rx,
    input  logic        set_ack,
    output logic [55:0] set_time,
    output logic        set_vld,
    output logic        frm_err,
    output logic        ovr_err
);
    import ds1302_pkg::*;

    localparam int            BAUD_DIV = CLK_FREQ / BAUD;
    localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC);
    localparam logic [2:0]    LAST_IDX = 3'(PAYLOAD_LEN - 1);
`ifdef UART_FRAME_CHECKSUM_EN
    localparam int            BUF_W    = 56;
`else
    localparam int            BUF_W    = 48;
`endif

    parser_state_t state, state_nxt;
    logic [7:0]    byte_data;
    logic          byte_vld, stop_err;
    logic [2:0]    pay_idx;
    logic [BUF_W-1:0] pay_buf;
    logic [TW-1:0] tmo_cnt;
    logic          bcd_err, tmo_err, chk_err, commit;
    logic [55:0]   commit_word;

    uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .rx       (uart_rx),
        .byte_data(byte_data),
        .byte_vld (byte_vld),
        .stop_err (stop_err)
    );

`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0] chk_sum;
    logic       chk_vld, chk_ok;

    // The checksum compare is registered, costing one extra cycle before commit.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            chk_sum <= '0;
            chk_vld <= 1'b0;
            chk_ok  <= 1'b0;
        end else begin
            chk_vld <= (state == CHECK) && byte_vld;
            chk_ok  <= (byte_data == chk_sum);
            if (state == WAIT_HDR)                 chk_sum <= HEADER;
            else if (state == PAYLOAD && byte_vld) chk_sum <= chk_sum + byte_data;
        end
    end

    assign commit_word = pay_buf;
`else
    assign commit_word = {pay_buf, byte_data};
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= WAIT_HDR;
        else         state <= state_nxt;
    end

    // A receiver framing error always drops the partial frame so the next header resynchronises.
    always_comb begin
        state_nxt = state;
        bcd_err   = 1'b0;
        tmo_err   = 1'b0;
        chk_err   = 1'b0;
        commit    = 1'b0;
        case (state)
            WAIT_HDR: begin
                if (byte_vld && byte_data == HEADER) state_nxt = PAYLOAD;
            end
            PAYLOAD: begin
                if (byte_vld) begin
                    if (!is_bcd(byte_data)) begin
                        bcd_err   = 1'b1;
                        state_nxt = WAIT_HDR;
                    end else if (pay_idx == LAST_IDX) begin
`ifdef UART_FRAME_CHECKSUM_EN
                        state_nxt = CHECK;
`else
                        commit    = 1'b1;
                        state_nxt = WAIT_HDR;
`endif
                    end
                end else if (tmo_cnt == TMO_MAX) begin
                    tmo_err   = 1'b1;
                    state_nxt = WAIT_HDR;
                end
            end
`ifdef UART_FRAME_CHECKSUM_EN
            CHECK: begin
                if (byte_vld) begin
                    state_nxt = WAIT_HDR;
                end else if (tmo_cnt == TMO_MAX) begin
                    tmo_err   = 1'b1;
                    state_nxt = WAIT_HDR;
                end
            end
`endif
            default: state_nxt = WAIT_HDR;
        endcase
`ifdef UART_FRAME_CHECKSUM_EN
        commit  = chk_vld && chk_ok;
        chk_err = chk_vld && !chk_ok;
`endif
        if (stop_err) state_nxt = WAIT_HDR;
    end

    // An ack in the commit cycle retires the pending word; the new frame is still an overrun.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pay_idx  <= '0;
            pay_buf  <= '0;
            tmo_cnt  <= '0;
            set_time <= '0;
            set_vld  <= 1'b0;
            frm_err  <= 1'b0;
            ovr_err  <= 1'b0;
        end else begin
            if (state == WAIT_HDR) begin
                pay_idx <= '0;
            end else if (state == PAYLOAD && byte_vld) begin
                pay_idx <= pay_idx + 3'd1;
                pay_buf <= {pay_buf[BUF_W-9:0], byte_data};
            end

            if (state == WAIT_HDR || byte_vld) tmo_cnt <= '0;
            else if (tmo_cnt != TMO_MAX)       tmo_cnt <= tmo_cnt + TW'(1);

            if (set_vld && set_ack) set_vld <= 1'b0;
            else if (commit)        set_vld <= 1'b1;
            if (commit && !set_vld) set_time <= commit_word;

            frm_err <= bcd_err || tmo_err || chk_err || stop_err;
            ovr_err <= commit && set_vld;
        end
    end

endmodule

// File: tb/tb_uart_time_rx.sv
// Scoreboard bench for uart_time_rx: directed frames, expected events queued, monitor pops on outputs.
module tb_uart_time_rx;
    localparam int CLK_FREQ    = 3_200_000;
    localparam int BAUD        = 100_000;
    localparam int BAUD_DIV    = CLK_FREQ / BAUD;
    localparam int TIMEOUT_CYC = 2000;
    localparam int EV_COMMIT   = 0;
    localparam int EV_FRM      = 1;
    localparam int EV_OVR      = 2;

    typedef struct {
        int          kind;
        logic [55:0] word;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic        set_ack = 1'b0;
    logic [55:0] set_time;
    logic        set_vld, frm_err, ovr_err;
    logic        prev_vld = 1'b0;

    uart_time_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .HEADER     (8'h55),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .uart_rx (uart_rx),
        .set_ack (set_ack),
        .set_time(set_time),
        .set_vld (set_vld),
        .frm_err (frm_err),
        .ovr_err (ovr_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string name, input logic [55:0] actual, input logic [55:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic expectEvent(input int kind, input logic [55:0] word);
        exp_t e;
        e.kind = kind;
        e.word = word;
        exp_q.push_back(e);
    endtask

    task automatic popCheck(input int kind, input logic [55:0] word);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_event: got kind %0d word %h expected none", kind, word);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == EV_COMMIT && word !== e.word)) begin
                failures++;
                $display("[TB] FAIL event: got kind %0d word %h expected kind %0d word %h",
                         kind, word, e.kind, e.word);
            end
        end
    endtask

    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (set_vld && !prev_vld) popCheck(EV_COMMIT, set_time);
            if (frm_err)              popCheck(EV_FRM, 56'h0);
            if (ovr_err)              popCheck(EV_OVR, 56'h0);
        end
        prev_vld = set_vld;
    end

    task automatic sendBit(input logic v);
        @(negedge sys_clk);
        uart_rx = v;
        repeat (BAUD_DIV - 1) @(negedge sys_clk);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stop_bit);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(b[i]);
        sendBit(stop_bit);
        if (!stop_bit) sendBit(1'b1);
    endtask

    // Sends the top nbytes of frame; byte bad_idx gets a low stop bit.
    task automatic applyStimulus(input logic [63:0] frame, input int nbytes, input int bad_idx);
        for (int i = 0; i < nbytes; i++) sendByte(frame[63-8*i -: 8], i != bad_idx);
`ifdef UART_FRAME_CHECKSUM_EN
        if (nbytes == 8 && bad_idx < 0) begin
            logic [7:0] sum;
            sum = 8'h00;
            for (int i = 0; i < 8; i++) sum = sum + frame[63-8*i -: 8];
            sendByte(sum, 1'b1);
        end
`endif
        repeat (2 * BAUD_DIV) @(negedge sys_clk);
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic ackWord(input string name);
        checkOutput({name, "_vld_before_ack"}, {55'h0, set_vld}, 56'h1);
        @(negedge sys_clk);
        set_ack = 1'b1;
        @(negedge sys_clk);
        set_ack = 1'b0;
        checkOutput({name, "_vld_after_ack"}, {55'h0, set_vld}, 56'h0);
    endtask

    initial begin
        $display("[TB] start, BAUD_DIV=%0d", BAUD_DIV);
        repeat (5) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        checkOutput("rst_time", set_time, 56'h0);
        checkOutput("rst_vld", {55'h0, set_vld}, 56'h0);
        checkOutput("rst_frm", {55'h0, frm_err}, 56'h0);
        checkOutput("rst_ovr", {55'h0, ovr_err}, 56'h0);

        $display("[TB] valid frame");
        expectEvent(EV_COMMIT, 56'h30_59_23_31_12_07_24);
        applyStimulus(64'h55_30_59_23_31_12_07_24, 8, -1);
        waitDrain(1000);
        checkOutput("valid_time", set_time, 56'h30_59_23_31_12_07_24);
        ackWord("valid");

        $display("[TB] BCD reject");
        expectEvent(EV_FRM, 56'h0);
        applyStimulus(64'h55_30_5A_00_00_00_00_00, 3, -1);
        waitDrain(1000);
        checkOutput("bcd_no_vld", {55'h0, set_vld}, 56'h0);
        expectEvent(EV_COMMIT, 56'h45_30_12_28_02_03_25);
        applyStimulus(64'h55_45_30_12_28_02_03_25, 8, -1);
        waitDrain(1000);
        ackWord("after_bcd");

        $display("[TB] framing error");
        expectEvent(EV_FRM, 56'h0);
        applyStimulus(64'h55_30_59_23_31_12_07_24, 8, 3);
        waitDrain(1000);
        checkOutput("frame_no_vld", {55'h0, set_vld}, 56'h0);
        expectEvent(EV_COMMIT, 56'h00_15_08_14_02_05_99);
        applyStimulus(64'h55_00_15_08_14_02_05_99, 8, -1);
        waitDrain(1000);
        ackWord("after_frame");

        $display("[TB] timeout");
        expectEvent(EV_FRM, 56'h0);
        applyStimulus(64'h55_30_59_00_00_00_00_00, 3, -1);
        waitDrain(TIMEOUT_CYC + 500);
        applyStimulus(64'h23_31_12_07_24_00_00_00, 5, -1);
        checkOutput("timeout_no_vld", {55'h0, set_vld}, 56'h0);
        expectEvent(EV_COMMIT, 56'h59_59_23_31_12_06_99);
        applyStimulus(64'h55_59_59_23_31_12_06_99, 8, -1);
        waitDrain(1000);
        ackWord("after_timeout");

        $display("[TB] overrun");
        expectEvent(EV_COMMIT, 56'h00_00_00_01_01_02_25);
        applyStimulus(64'h55_00_00_00_01_01_02_25, 8, -1);
        expectEvent(EV_OVR, 56'h0);
        applyStimulus(64'h55_11_22_13_15_06_04_26, 8, -1);
        waitDrain(1000);
        checkOutput("ovr_time_hold", set_time, 56'h00_00_00_01_01_02_25);
        checkOutput("ovr_vld_hold", {55'h0, set_vld}, 56'h1);

        $display("[TB] reset mid-frame");
        applyStimulus(64'h55_30_59_23_00_00_00_00, 4, -1);
        @(negedge sys_clk);
        uart_rx = 1'b0;
        repeat (10) @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        uart_rx = 1'b1;
        @(negedge sys_clk);
        checkOutput("midrst_time", set_time, 56'h0);
        checkOutput("midrst_vld", {55'h0, set_vld}, 56'h0);
        checkOutput("midrst_frm", {55'h0, frm_err}, 56'h0);
        checkOutput("midrst_ovr", {55'h0, ovr_err}, 56'h0);
        expectEvent(EV_COMMIT, 56'h21_43_09_27_11_03_24);
        applyStimulus(64'h55_21_43_09_27_11_03_24, 8, -1);
        waitDrain(1000);
        ackWord("after_rst");

        $display("[TB] glitch");
        @(negedge sys_clk);
        uart_rx = 1'b0;
        repeat (7) @(negedge sys_clk);
        uart_rx = 1'b1;
        repeat (300) @(negedge sys_clk);
        checkOutput("glitch_no_vld", {55'h0, set_vld}, 56'h0);
        expectEvent(EV_COMMIT, 56'h05_10_18_04_07_05_25);
        applyStimulus(64'h55_05_10_18_04_07_05_25, 8, -1);
        waitDrain(1000);
        ackWord("after_glitch");

        repeat (20) @(negedge sys_clk);
        checkOutput("queue_empty", 56'(exp_q.size()), 56'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
